// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with shadow/active code registers.
// Optional anti-ghosting blank interval between digits: define SEG_SCAN_GUARD_EN.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_MAX      = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [2:0]            wr_data,
    input  logic                  commit,
    output logic [2:0]            seg_code,
    output logic [NUM_DIGITS-1:0] digit_sel_n,
    output logic [2:0]            scan_idx,
    output logic                  commit_pending,
    output logic                  frame_done
);

    localparam int unsigned CW    = 3;
    localparam int unsigned DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [CW-1:0]    IDX_LAST = CW'(NUM_DIGITS - 1);
    // An illegal parameter set leaves the scanner parked in IDLE.
    localparam bit CFG_OK = (NUM_DIGITS >= 2) && (NUM_DIGITS <= 8) &&
                            (DIV_MAX >= 1) && (DIV_MAX <= 65536) && (GUARD_CYCLES >= 1);

`ifdef SEG_SCAN_GUARD_EN
    localparam logic [DIV_W-1:0] GUARD_LAST = DIV_W'(GUARD_CYCLES - 1);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GUARD} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_DRIVE} state_e;
`endif

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [CW-1:0]          scan_idx_q, scan_idx_d;
    logic [CW-1:0]          seg_code_q, seg_code_d;
    logic [NUM_DIGITS-1:0]  digit_sel_n_q, digit_sel_n_d;
    logic                   commit_pending_q, commit_pending_d;
    logic                   frame_done_q, frame_done_d;
    logic [CW-1:0]          shadow_q [NUM_DIGITS];
    logic [CW-1:0]          shadow_d [NUM_DIGITS];
    logic [CW-1:0]          active_q [NUM_DIGITS];
    logic [CW-1:0]          active_d [NUM_DIGITS];
    logic                   scan_go;
    logic                   advance;

    always_comb begin
        state_d          = state_q;
        div_d            = div_q;
        scan_idx_d       = scan_idx_q;
        seg_code_d       = seg_code_q;
        digit_sel_n_d    = digit_sel_n_q;
        commit_pending_d = commit_pending_q | commit;
        frame_done_d     = 1'b0;
        shadow_d         = shadow_q;
        active_d         = active_q;
        advance          = 1'b0;
        scan_go          = enable && CFG_OK;

        if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == CW'(i)) shadow_d[i] = wr_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                div_d         = '0;
                scan_idx_d    = '0;
                digit_sel_n_d = '1;
                // Copy uses the pre-edge shadow; a commit this cycle waits for the next chance.
                if (commit_pending_q) begin
                    active_d         = shadow_q;
                    commit_pending_d = commit;
                end
                if (scan_go) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (!scan_go) begin
                    state_d       = S_IDLE;
                    div_d         = '0;
                    scan_idx_d    = '0;
                    digit_sel_n_d = '1;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
`ifdef SEG_SCAN_GUARD_EN
                    state_d       = S_GUARD;
                    digit_sel_n_d = '1;
`else
                    advance = 1'b1;
`endif
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`ifdef SEG_SCAN_GUARD_EN
            S_GUARD: begin
                if (!scan_go) begin
                    state_d       = S_IDLE;
                    div_d         = '0;
                    scan_idx_d    = '0;
                    digit_sel_n_d = '1;
                end else if (div_q == GUARD_LAST) begin
                    div_d   = '0;
                    state_d = S_DRIVE;
                    advance = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Frame wrap: pulse frame_done and apply a commit accepted before this cycle.
        if (advance) begin
            if (scan_idx_q == IDX_LAST) begin
                scan_idx_d   = '0;
                frame_done_d = 1'b1;
                if (commit_pending_q) begin
                    active_d         = shadow_q;
                    commit_pending_d = commit;
                end
            end else begin
                scan_idx_d = scan_idx_q + CW'(1);
            end
        end

        if (state_d == S_DRIVE) begin
            digit_sel_n_d = '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (scan_idx_d == CW'(i)) begin
                    digit_sel_n_d[i] = 1'b0;
                    seg_code_d       = active_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            div_q            <= '0;
            scan_idx_q       <= '0;
            seg_code_q       <= '0;
            digit_sel_n_q    <= '1;
            commit_pending_q <= 1'b0;
            frame_done_q     <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            div_q            <= div_d;
            scan_idx_q       <= scan_idx_d;
            seg_code_q       <= seg_code_d;
            digit_sel_n_q    <= digit_sel_n_d;
            commit_pending_q <= commit_pending_d;
            frame_done_q     <= frame_done_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
        end
    end

    assign seg_code       = seg_code_q;
    assign digit_sel_n    = digit_sel_n_q;
    assign scan_idx       = scan_idx_q;
    assign commit_pending = commit_pending_q;
    assign frame_done     = frame_done_q;

endmodule
